instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage and producer side of the IF/ID pipeline register: holds the PC and reads
//  the program from an internal instruction memory, which the debug unit loads.
//  Drives next_seq_pc/instruction/halt into IF/ID and stops at the halt opcode.
//  Stall/redirect inputs come from the hazard unit and the ID branch/jump logic.
// PARAMETERS
//  PC_SIZE          32          PC / address width (bits)
//  INSTRUCTION_SIZE 32          instruction width (bits)
//  MEM_DEPTH        256         instruction memory depth (words)
//  COUNT_SIZE       32          fetched-instruction counter width
// PORTS
//  i_clk            in   1      clock, all state on posedge
//  i_reset          in   1      synchronous, active-high reset
//  i_enable         in   1      hazard unit: 0 = stall (PC holds)
//  i_run            in   1      debug: continuous-run mode
//  i_step           in   1      debug: single-cycle advance pulse
//  i_restart        in   1      leave HALTED, PC <= 0
//  i_jump           in   1      redirect request from ID
//  i_jump_addr      in   PC     redirect target (byte address)
//  i_mem_wr_en      in   1      loader write strobe
//  i_mem_wr_addr    in   log2(MEM_DEPTH) loader word index
//  i_mem_wr_data    in   INSTR  loader word
//  o_pc             out  PC     current PC
//  o_next_seq_pc    out  PC     o_pc + 4 (to IF/ID)
//  o_instruction    out  INSTR  instruction at o_pc (to IF/ID)
//  o_halt           out  1      o_instruction is halt (to IF/ID)
//  o_halted         out  1      FSM in HALTED
//  o_fetch_count    out  COUNT  instructions fetched since reset/restart
// BEHAVIOUR
//  - Reset: PC=0, state RUN, count=0. o_halted=0. Memory contents are NOT cleared.
//  - FSM states: RUN and HALTED.
//    - RUN->HALTED on an advance cycle whose fetched word is HALT.
//    - HALTED->RUN only on i_restart.
//    - Reset has priority over restart.
//  - go = state==RUN && (i_run || i_step).
//  - advance = go && i_enable.
//  - PC update, in priority order:
//    1. Reset.
//    2. Restart: PC=0.
//    3. go && i_jump: PC = {i_jump_addr[PC-1:2], 2'b00}. Jumps override stalls.
//    4. advance && !halt: PC = PC+4, wrapping mod 2^PC_SIZE.
//    5. Otherwise PC holds.
//  - A halt fetch does not increment the PC: it stays on the halt word.
//  - Read path is combinational.
//    - word = PC[2 +: log2(MEM_DEPTH)].
//    - If PC >= 4*MEM_DEPTH, the word is HALT_OPCODE (treated as halt).
//  - o_halt = (fetched word == HALT_OPCODE) || out-of-range.
//    - It is still computed while stalled.
//    - In HALTED, o_instruction = HALT_OPCODE and o_halt = 1.
//  - Writes land on the posedge and are visible on the next cycle.
//    - A write to the current word shows the old data in the same cycle.
//    - Writes are accepted in any state, including mid-run.
//  - o_fetch_count:
//    - Increments once per advance or go&&i_jump cycle, counted once if both.
//    - The halt fetch is counted.
//    - Saturates at all-ones.
//    - Cleared by reset and by i_restart.
//  - i_step is edge-agnostic: each cycle it is high counts as one go.
//  - o_pc, o_next_seq_pc, o_halted and o_fetch_count are registered or derived from registers.
//  - Fetch-to-IF/ID latency is 0 cycles: IF/ID captures the outputs on the next posedge.
// STRUCTURE
//  - Shared package: HALT_OPCODE=32'hFFFF_FFFF, NOP=32'h0, FSM state encodings
//    (ST_RUN, ST_HALTED), PC_INCR=4.
//  - Sub-module instruction_memory: MEM_DEPTH x INSTRUCTION_SIZE, 1 sync write port,
//    1 async read port.
//  - PC, FSM and counter stay in the top module.
// TESTING
//  1. Reset, load mem[0..3] = {A,B,C,FFFFFFFF}, i_run=1, i_enable=1
//     -> o_pc 0,4,8,12; o_halted=1 next cycle; o_fetch_count=4; PC holds at 12.
//  2. Run with i_enable=0 for 3 cycles at PC=4
//     -> PC stays 4, o_instruction=B, count unchanged; resumes to 8 when enable=1.
//  3. i_jump=1, i_jump_addr=0x23, i_enable=0, at PC=4
//     -> next o_pc=0x20, count+1.
//  4. i_run=0, pulse i_step for 1 cycle twice
//     -> PC 0->4->8, count=2; no motion between pulses.
//  5. PC=4*MEM_DEPTH-4 holding a non-halt word, advance
//     -> PC=4*MEM_DEPTH, o_halt=1, then HALTED.
//  6. In HALTED, assert i_restart while writing mem[0]=D
//     -> PC=0, count=0, RUN; o_instruction=D the following cycle.
//  7. Mid-run reset -> PC=0, count=0, previously loaded program still present.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the IF stage.
// Latency: n/a. Backpressure: n/a.
package instruction_fetch_pkg;

  localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam int          PC_INCR     = 4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction store: one synchronous write port for the loader, one async read port.
// Latency: read 0 cycles, write visible next cycle. Backpressure: none, always accepts.
module instruction_memory #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_W           = $clog2(MEM_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_wr_en,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  output logic [INSTRUCTION_SIZE-1:0] o_rd_data
);

  // Deliberately unreset: the program must survive a pipeline reset.
  logic [INSTRUCTION_SIZE-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, RUN/HALTED FSM, fetch counter, and combinational instruction fetch.
// Latency: 0 cycles to IF/ID. Backpressure: i_enable low stalls the PC; a jump still redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE          = 32,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int COUNT_SIZE       = 32,
  parameter int ADDR_W           = $clog2(MEM_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_run,
  input  logic                        i_step,
  input  logic                        i_restart,
  input  logic                        i_jump,
  input  logic [PC_SIZE-1:0]          i_jump_addr,
  input  logic                        i_mem_wr_en,
  input  logic [ADDR_W-1:0]           i_mem_wr_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_mem_wr_data,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic [PC_SIZE-1:0]          o_next_seq_pc,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_halt,
  output logic                        o_halted,
  output logic [COUNT_SIZE-1:0]       o_fetch_count
);

  localparam logic [INSTRUCTION_SIZE-1:0] HALT_WORD = INSTRUCTION_SIZE'(HALT_OPCODE);
  localparam logic [PC_SIZE-1:0]          PC_STEP   = PC_SIZE'(PC_INCR);
  localparam logic [PC_SIZE-1:0]          PC_LIMIT  = PC_SIZE'(PC_INCR * MEM_DEPTH);

  fetch_state_e                state_q, state_d;
  logic [PC_SIZE-1:0]          pc_q, pc_d;
  logic [COUNT_SIZE-1:0]       count_q, count_d;

  logic [INSTRUCTION_SIZE-1:0] mem_rd_data;
  logic [INSTRUCTION_SIZE-1:0] fetched_word;
  logic                        out_of_range;
  logic                        fetched_halt;
  logic                        go;
  logic                        advance;
  logic                        jump_taken;
  logic [PC_SIZE-1:0]          jump_target;

  instruction_memory #(
    .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
    .MEM_DEPTH        (MEM_DEPTH),
    .ADDR_W           (ADDR_W)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_mem_wr_en),
    .i_wr_addr (i_mem_wr_addr),
    .i_wr_data (i_mem_wr_data),
    .i_rd_addr (pc_q[2 +: ADDR_W]),
    .o_rd_data (mem_rd_data)
  );

  // Fetching past the end of memory behaves as if a halt word were stored there.
  assign out_of_range = (pc_q >= PC_LIMIT);
  assign fetched_word = out_of_range ? HALT_WORD : mem_rd_data;
  assign fetched_halt = (fetched_word == HALT_WORD);

  assign go          = (state_q == ST_RUN) && (i_run || i_step);
  assign advance     = go && i_enable;
  assign jump_taken  = go && i_jump;
  assign jump_target = i_jump_addr & ~PC_SIZE'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    if (i_restart) begin
      state_d = ST_RUN;
      pc_d    = '0;
      count_d = '0;
    end else begin
      if (jump_taken) begin
        pc_d = jump_target;
      end else if (advance && !fetched_halt) begin
        pc_d = pc_q + PC_STEP;
      end

      if (advance && fetched_halt) begin
        state_d = ST_HALTED;
      end

      if ((advance || jump_taken) && (count_q != '1)) begin
        count_d = count_q + COUNT_SIZE'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_next_seq_pc = pc_q + PC_STEP;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_instruction = o_halted ? HALT_WORD : fetched_word;
  assign o_halt        = o_halted || fetched_halt;
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  localparam logic [31:0] W_A  = 32'h1111_1111;
  localparam logic [31:0] W_B  = 32'h2222_2222;
  localparam logic [31:0] W_C  = 32'h3333_3333;
  localparam logic [31:0] W_D  = 32'hDDDD_DDDD;
  localparam logic [31:0] W_E  = 32'h5555_5555;
  localparam logic [31:0] W_F  = 32'h0A0A_0A0A;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_run, i_step, i_restart, i_jump, i_mem_wr_en;
  logic [31:0] i_jump_addr, i_mem_wr_data;
  logic [7:0]  i_mem_wr_addr;
  logic [31:0] o_pc, o_next_seq_pc, o_instruction, o_fetch_count;
  logic        o_halt, o_halted;

  int total = 0;
  int bad   = 0;

  instruction_fetch dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_run         (i_run),
    .i_step        (i_step),
    .i_restart     (i_restart),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_mem_wr_en   (i_mem_wr_en),
    .i_mem_wr_addr (i_mem_wr_addr),
    .i_mem_wr_data (i_mem_wr_data),
    .o_pc          (o_pc),
    .o_next_seq_pc (o_next_seq_pc),
    .o_instruction (o_instruction),
    .o_halt        (o_halt),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = addr;
    i_mem_wr_data = data;
    tick();
    i_mem_wr_en   = 1'b0;
  endtask

  task automatic restart();
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h0); end
    total++; if (o_next_seq_pc !== 32'h4) begin bad++; $display("FAIL reset_next_pc got=%h exp=%h", o_next_seq_pc, 32'h4); end
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", o_halted); end
    total++; if (o_fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_fetch_count); end
  endtask

  task automatic test_run_to_halt();
    load(8'd0, W_A);
    load(8'd1, W_B);
    load(8'd2, W_C);
    load(8'd3, HALT);
    total++; if (o_instruction !== W_A) begin bad++; $display("FAIL run_instr0 got=%h exp=%h", o_instruction, W_A); end
    i_run = 1'b1; i_enable = 1'b1;
    tick();
    total++; if (o_pc !== 32'd4) begin bad++; $display("FAIL run_pc4 got=%h exp=%h", o_pc, 32'd4); end
    tick();
    total++; if (o_pc !== 32'd8) begin bad++; $display("FAIL run_pc8 got=%h exp=%h", o_pc, 32'd8); end
    tick();
    total++; if (o_pc !== 32'd12) begin bad++; $display("FAIL run_pc12 got=%h exp=%h", o_pc, 32'd12); end
    total++; if (o_halt !== 1'b1) begin bad++; $display("FAIL run_halt_flag got=%b exp=1", o_halt); end
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL run_not_yet_halted got=%b exp=0", o_halted); end
    tick();
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL run_halted got=%b exp=1", o_halted); end
    total++; if (o_fetch_count !== 32'd4) begin bad++; $display("FAIL run_count got=%0d exp=4", o_fetch_count); end
    tick();
    total++; if (o_pc !== 32'd12) begin bad++; $display("FAIL run_pc_hold got=%h exp=%h", o_pc, 32'd12); end
    total++; if (o_fetch_count !== 32'd4) begin bad++; $display("FAIL run_count_hold got=%0d exp=4", o_fetch_count); end
    i_run = 1'b0;
  endtask

  task automatic test_stall();
    restart();
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL stall_restart_halted got=%b exp=0", o_halted); end
    i_run = 1'b1; i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    repeat (3) tick();
    total++; if (o_pc !== 32'd4) begin bad++; $display("FAIL stall_pc got=%h exp=%h", o_pc, 32'd4); end
    total++; if (o_instruction !== W_B) begin bad++; $display("FAIL stall_instr got=%h exp=%h", o_instruction, W_B); end
    total++; if (o_fetch_count !== 32'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", o_fetch_count); end
    i_enable = 1'b1;
    tick();
    total++; if (o_pc !== 32'd8) begin bad++; $display("FAIL stall_resume_pc got=%h exp=%h", o_pc, 32'd8); end
    total++; if (o_fetch_count !== 32'd2) begin bad++; $display("FAIL stall_resume_count got=%0d exp=2", o_fetch_count); end
    i_run = 1'b0;
  endtask

  task automatic test_jump();
    restart();
    i_run = 1'b1; i_enable = 1'b1;
    tick();
    i_enable = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h23;
    tick();
    i_jump = 1'b0; i_run = 1'b0;
    total++; if (o_pc !== 32'h20) begin bad++; $display("FAIL jump_pc got=%h exp=%h", o_pc, 32'h20); end
    total++; if (o_next_seq_pc !== 32'h24) begin bad++; $display("FAIL jump_next_pc got=%h exp=%h", o_next_seq_pc, 32'h24); end
    total++; if (o_fetch_count !== 32'd2) begin bad++; $display("FAIL jump_count got=%0d exp=2", o_fetch_count); end
  endtask

  task automatic test_step();
    restart();
    i_enable = 1'b1;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    total++; if (o_pc !== 32'd4) begin bad++; $display("FAIL step1_pc got=%h exp=%h", o_pc, 32'd4); end
    tick();
    tick();
    total++; if (o_pc !== 32'd4) begin bad++; $display("FAIL step_idle_pc got=%h exp=%h", o_pc, 32'd4); end
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    total++; if (o_pc !== 32'd8) begin bad++; $display("FAIL step2_pc got=%h exp=%h", o_pc, 32'd8); end
    total++; if (o_fetch_count !== 32'd2) begin bad++; $display("FAIL step_count got=%0d exp=2", o_fetch_count); end
  endtask

  task automatic test_wrap();
    restart();
    i_run = 1'b1; i_enable = 1'b0; i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFF;
    tick();
    i_jump = 1'b0; i_run = 1'b0;
    total++; if (o_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", o_pc, 32'hFFFF_FFFC); end
    total++; if (o_next_seq_pc !== 32'h0) begin bad++; $display("FAIL wrap_next_pc got=%h exp=%h", o_next_seq_pc, 32'h0); end
    total++; if (o_halt !== 1'b1) begin bad++; $display("FAIL wrap_oor_halt got=%b exp=1", o_halt); end
  endtask

  task automatic test_mem_end();
    load(8'd255, W_E);
    restart();
    i_run = 1'b1; i_enable = 1'b0; i_jump = 1'b1; i_jump_addr = 32'd1020;
    tick();
    i_jump = 1'b0; i_enable = 1'b1;
    total++; if (o_instruction !== W_E) begin bad++; $display("FAIL end_last_word got=%h exp=%h", o_instruction, W_E); end
    total++; if (o_halt !== 1'b0) begin bad++; $display("FAIL end_last_halt got=%b exp=0", o_halt); end
    tick();
    total++; if (o_pc !== 32'd1024) begin bad++; $display("FAIL end_oor_pc got=%h exp=%h", o_pc, 32'd1024); end
    total++; if (o_halt !== 1'b1) begin bad++; $display("FAIL end_oor_halt got=%b exp=1", o_halt); end
    total++; if (o_instruction !== HALT) begin bad++; $display("FAIL end_oor_instr got=%h exp=%h", o_instruction, HALT); end
    tick();
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL end_halted got=%b exp=1", o_halted); end
    total++; if (o_pc !== 32'd1024) begin bad++; $display("FAIL end_pc_hold got=%h exp=%h", o_pc, 32'd1024); end
    total++; if (o_fetch_count !== 32'd3) begin bad++; $display("FAIL end_count got=%0d exp=3", o_fetch_count); end
    i_run = 1'b0; i_enable = 1'b0;
  endtask

  task automatic test_restart_write();
    i_restart = 1'b1;
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd0; i_mem_wr_data = W_D;
    tick();
    i_restart = 1'b0; i_mem_wr_en = 1'b0;
    total++; if (o_pc !== 32'd0) begin bad++; $display("FAIL rst_wr_pc got=%h exp=%h", o_pc, 32'd0); end
    total++; if (o_fetch_count !== 32'd0) begin bad++; $display("FAIL rst_wr_count got=%0d exp=0", o_fetch_count); end
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL rst_wr_halted got=%b exp=0", o_halted); end
    total++; if (o_instruction !== W_D) begin bad++; $display("FAIL rst_wr_instr got=%h exp=%h", o_instruction, W_D); end
    i_mem_wr_en = 1'b1; i_mem_wr_addr = 8'd0; i_mem_wr_data = W_F;
    #1;
    total++; if (o_instruction !== W_D) begin bad++; $display("FAIL wr_same_cycle got=%h exp=%h", o_instruction, W_D); end
    tick();
    i_mem_wr_en = 1'b0;
    total++; if (o_instruction !== W_F) begin bad++; $display("FAIL wr_next_cycle got=%h exp=%h", o_instruction, W_F); end
  endtask

  task automatic test_midrun_reset();
    i_run = 1'b1; i_enable = 1'b1;
    tick();
    tick();
    total++; if (o_pc !== 32'd8) begin bad++; $display("FAIL mid_pre_pc got=%h exp=%h", o_pc, 32'd8); end
    i_reset = 1'b1; i_run = 1'b0;
    tick();
    i_reset = 1'b0;
    total++; if (o_pc !== 32'd0) begin bad++; $display("FAIL mid_pc got=%h exp=%h", o_pc, 32'd0); end
    total++; if (o_fetch_count !== 32'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", o_fetch_count); end
    total++; if (o_instruction !== W_F) begin bad++; $display("FAIL mid_mem0 got=%h exp=%h", o_instruction, W_F); end
    i_step = 1'b1;
    tick();
    total++; if (o_instruction !== W_B) begin bad++; $display("FAIL mid_mem1 got=%h exp=%h", o_instruction, W_B); end
    tick();
    i_step = 1'b0;
    total++; if (o_instruction !== W_C) begin bad++; $display("FAIL mid_mem2 got=%h exp=%h", o_instruction, W_C); end
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_run = 1'b0; i_step = 1'b0;
    i_restart = 1'b0; i_jump = 1'b0; i_jump_addr = '0;
    i_mem_wr_en = 1'b0; i_mem_wr_addr = '0; i_mem_wr_data = '0;
    test_reset();
    test_run_to_halt();
    test_stall();
    test_jump();
    test_step();
    test_wrap();
    test_mem_end();
    test_restart_write();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
